// File: rtl/clock_ctrl_pkg.sv
// Shared types and digit limits for the HH:MM:SS timekeeping chain.
package clock_ctrl_pkg;

    // Set-mode FSM states; encoding 2'd3 is unused and recovers to RUN.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    // Largest legal value of each kind of BCD digit.
    localparam logic [3:0] ONES_MAX     = 4'd9;  // any ones digit
    localparam logic [3:0] TENS_MAX     = 4'd5;  // seconds/minutes tens
    localparam logic [3:0] HR_TENS_MAX  = 4'd2;  // hours tens
    localparam logic [3:0] HR_ONES_WRAP = 4'd3;  // hours ones at 23 -> 00

endpackage

// File: rtl/clock_time_controller_bcd_digit.sv
// One BCD digit register that wraps at MAX and emits a carry on wrap.
module bcd_digit
    import clock_ctrl_pkg::*;
#(
    parameter logic [3:0] MAX     = ONES_MAX,
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [3:0] q_o,
    output logic       carry_o
);

    logic [3:0] val_q;
    logic [3:0] val_d;

    // Carry fires on the enabled wrap so the next digit advances on the same edge.
    assign carry_o = en_i && (val_q == MAX);
    assign q_o     = val_q;

    // Next value: clear wins, out-of-range values snap back to 0.
    always_comb begin
        val_d = val_q;
        if (clr_i || (val_q > MAX)) begin
            val_d = 4'd0;
        end else if (en_i) begin
            val_d = (val_q == MAX) ? 4'd0 : val_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) val_q <= RST_VAL;
        else     val_q <= val_d;
    end

endmodule

// File: rtl/clock_time_controller.sv
// Digital-clock sequencer: 1 Hz prescaler, HH:MM:SS BCD chain and set-mode FSM.
module clock_time_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int START_HR  = 0,
    parameter int START_MIN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_p,
    input  logic       inc_p,
    output logic [3:0] hr_t,
    output logic [3:0] hr_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic       tick,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       setting
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    logic pre_wrap, blink, sec_clr, adj_hr, adj_min, hr_en, hr_wrap, hr_clr;
    logic sec_o_carry, sec_t_carry, min_o_carry, min_t_carry, hr_o_carry, hr_t_carry;

    assign pre_wrap = (pre_q == PRE_LAST);
    assign blink    = (pre_q >= PRE_HALF);

    // FSM next state and derived control; mode_p beats inc_p on the same cycle.
    always_comb begin
        state_d = state_q;
        sec_clr = 1'b0;
        adj_hr  = 1'b0;
        adj_min = 1'b0;
        case (state_q)
            RUN: begin
                if (mode_p) begin
                    state_d = SET_HR;
                    sec_clr = 1'b1;
                end
            end
            SET_HR: begin
                if (mode_p) state_d = SET_MIN;
                else        adj_hr  = inc_p;
            end
            SET_MIN: begin
                if (mode_p) state_d = RUN;
                else        adj_min = inc_p;
            end
            default: state_d = RUN;
        endcase
    end

    // Prescaler restarts on leaving set mode so a full period precedes the first tick.
    always_comb begin
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        if (state_q == SET_MIN && mode_p) pre_d = '0;
        tick_d = pre_wrap && (state_q == RUN) && (state_d == RUN);
    end

    // State, prescaler and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pre_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
        end
    end

    // Hours advance from the minute carry only while running; a set-minute
    // wrap must not leak into hours. 23 -> 00 clears both hour digits.
    assign hr_en   = ((state_q == RUN) && min_t_carry) || adj_hr;
    assign hr_wrap = hr_en && (hr_t == HR_TENS_MAX) && (hr_o == HR_ONES_WRAP);
    assign hr_clr  = hr_wrap || hr_t_carry;

    bcd_digit #(.MAX(ONES_MAX), .RST_VAL(4'd0)) u_sec_o (
        .clk(clk), .rst(rst), .en_i(tick_q), .clr_i(sec_clr),
        .q_o(sec_o), .carry_o(sec_o_carry));

    bcd_digit #(.MAX(TENS_MAX), .RST_VAL(4'd0)) u_sec_t (
        .clk(clk), .rst(rst), .en_i(sec_o_carry), .clr_i(sec_clr),
        .q_o(sec_t), .carry_o(sec_t_carry));

    bcd_digit #(.MAX(ONES_MAX), .RST_VAL(4'(START_MIN % 10))) u_min_o (
        .clk(clk), .rst(rst), .en_i(sec_t_carry || adj_min), .clr_i(1'b0),
        .q_o(min_o), .carry_o(min_o_carry));

    bcd_digit #(.MAX(TENS_MAX), .RST_VAL(4'(START_MIN / 10))) u_min_t (
        .clk(clk), .rst(rst), .en_i(min_o_carry), .clr_i(1'b0),
        .q_o(min_t), .carry_o(min_t_carry));

    bcd_digit #(.MAX(ONES_MAX), .RST_VAL(4'(START_HR % 10))) u_hr_o (
        .clk(clk), .rst(rst), .en_i(hr_en && !hr_wrap), .clr_i(hr_clr),
        .q_o(hr_o), .carry_o(hr_o_carry));

    bcd_digit #(.MAX(HR_TENS_MAX), .RST_VAL(4'(START_HR / 10))) u_hr_t (
        .clk(clk), .rst(rst), .en_i(hr_o_carry), .clr_i(hr_clr),
        .q_o(hr_t), .carry_o(hr_t_carry));

    assign tick      = tick_q;
    assign setting   = (state_q == SET_HR) || (state_q == SET_MIN);
    assign blank_hr  = (state_q == SET_HR)  && blink;
    assign blank_min = (state_q == SET_MIN) && blink;

endmodule

// File: tb/tb_clock_time_controller.sv
// Randomised and directed bench for clock_time_controller against a time-of-day model.
module tb_clock_time_controller;

  localparam int TD = 4;
  localparam int SH = 12;
  localparam int SM = 34;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_p;
  logic       inc_p;
  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic       tick, blank_hr, blank_min, setting;

  int checks = 0;
  int errors = 0;

  // model: seconds of day, mode (0 run, 1 set hours, 2 set minutes), phase count, strobe
  int m_tod;
  int m_mode;
  int m_pre;
  int m_tick;

  clock_time_controller #(.TICK_DIV(TD), .START_HR(SH), .START_MIN(SM)) dut (
    .clk(clk), .rst(rst), .mode_p(mode_p), .inc_p(inc_p),
    .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o), .tick(tick),
    .blank_hr(blank_hr), .blank_min(blank_min), .setting(setting)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_hours();
    return int'(hr_t) * 10 + int'(hr_o);
  endfunction

  function automatic int dut_mins();
    return int'(min_t) * 10 + int'(min_o);
  endfunction

  function automatic int dut_secs();
    return int'(sec_t) * 10 + int'(sec_o);
  endfunction

  task automatic model_reset();
    m_tod  = SH * 3600 + SM * 60;
    m_mode = 0;
    m_pre  = 0;
    m_tick = 0;
  endtask

  // one clock edge of the reference behaviour
  task automatic model_step(input bit m, input bit i);
    int h, mi, s, nmode, npre, ntick;
    if (m_tick != 0) m_tod = (m_tod + 1) % 86400;
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    if (m_mode == 0 && m) s = 0;
    if (m_mode == 1 && i && !m) h = (h + 1) % 24;
    if (m_mode == 2 && i && !m) mi = (mi + 1) % 60;
    m_tod = h * 3600 + mi * 60 + s;
    nmode = m ? (m_mode + 1) % 3 : m_mode;
    npre  = (m_mode == 2 && m) ? 0 : (m_pre + 1) % TD;
    ntick = (m_pre == TD - 1 && m_mode == 0 && nmode == 0) ? 1 : 0;
    m_mode = nmode;
    m_pre  = npre;
    m_tick = ntick;
  endtask

  task automatic compare_all();
    int h, mi, s;
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    check("hr_t", hr_t, h / 10);
    check("hr_o", hr_o, h % 10);
    check("min_t", min_t, mi / 10);
    check("min_o", min_o, mi % 10);
    check("sec_t", sec_t, s / 10);
    check("sec_o", sec_o, s % 10);
    check("tick", tick, m_tick);
    check("setting", setting, (m_mode != 0) ? 1 : 0);
    check("blank_hr", blank_hr, (m_mode == 1 && m_pre >= TD / 2) ? 1 : 0);
    check("blank_min", blank_min, (m_mode == 2 && m_pre >= TD / 2) ? 1 : 0);
  endtask

  // driver: hold inputs across one rising edge, then compare on the falling edge
  task automatic step(input bit m, input bit i);
    mode_p = m;
    inc_p  = i;
    @(posedge clk);
    model_step(m, i);
    @(negedge clk);
    mode_p = 1'b0;
    inc_p  = 1'b0;
    compare_all();
  endtask

  // steps until the DUT shows tick (inclusive); returns the count, 99 on timeout
  task automatic steps_to_tick(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (tick !== 1'b1 && n < 40);
    if (tick !== 1'b1) n = 99;
  endtask

  // load hours and minutes through set mode, ending back in RUN
  task automatic set_time(input int h, input int mi);
    int ch, cm;
    step(1'b1, 1'b0);
    ch = m_tod / 3600;
    repeat ((h - ch + 24) % 24) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    cm = (m_tod / 60) % 60;
    repeat ((mi - cm + 60) % 60) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
  endtask

  task automatic run_to(input int target, input string tag);
    int n;
    n = 0;
    while (m_tod != target && n < 1000) begin
      step(1'b0, 1'b0);
      n++;
    end
    check(tag, dut_hours() * 3600 + dut_mins() * 60 + dut_secs(), target);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    mode_p = 1'b0;
    inc_p  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // reset values and first tick latency
    steps_to_tick(n);
    check("first_tick_cycles", n, 4);
    check("sec_before_tick", dut_secs(), 0);
    step(1'b0, 1'b0);
    check("sec_after_tick", dut_secs(), 1);

    // midnight rollover in one cycle
    set_time(23, 59);
    run_to(23 * 3600 + 59 * 60 + 58, "preload_235958");
    steps_to_tick(n);
    step(1'b0, 1'b0);
    check("roll_235959", dut_hours() * 3600 + dut_mins() * 60 + dut_secs(), 86399);
    steps_to_tick(n);
    step(1'b0, 1'b0);
    check("roll_000000", dut_hours() * 3600 + dut_mins() * 60 + dut_secs(), 0);

    // enter SET_HR from 10:20:37, no ticks, hours wrap through 23
    set_time(10, 20);
    run_to(10 * 3600 + 20 * 60 + 37, "preload_102037");
    step(1'b1, 1'b0);
    check("set_hr_setting", setting, 1);
    check("set_hr_sec_clr", dut_secs(), 0);
    n = 0;
    repeat (20) begin
      step(1'b0, 1'b0);
      if (tick === 1'b1) n++;
    end
    check("set_hr_no_tick", n, 0);
    repeat (14) step(1'b0, 1'b1);
    check("hr_wrap_to_00", dut_hours(), 0);

    // minute wrap without hour carry, then first tick after leaving set mode
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat ((59 - dut_mins() + 60) % 60) step(1'b0, 1'b1);
    check("min_at_59", dut_mins(), 59);
    step(1'b0, 1'b1);
    check("min_wrap_00", dut_mins(), 0);
    check("min_wrap_hr", dut_hours(), 5);
    step(1'b1, 1'b0);
    check("back_to_run", setting, 0);
    steps_to_tick(n);
    check("run_first_tick", n, 4);

    // mode_p and inc_p together in SET_HR at 07
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("hr_at_07", dut_hours(), 7);
    step(1'b1, 1'b1);
    check("both_hr_kept", dut_hours(), 7);
    check("both_setting", setting, 1);
    step(1'b0, 1'b1);
    check("both_now_set_min", dut_mins(), (m_tod / 60) % 60);
    check("both_hr_still", dut_hours(), 7);

    // asynchronous reset mid-cycle while blank_min is high
    n = 0;
    while (blank_min !== 1'b1 && n < 10) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("blank_min_seen", blank_min, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_hours", dut_hours(), SH);
    check("arst_mins", dut_mins(), SM);
    check("arst_secs", dut_secs(), 0);
    check("arst_blank_min", blank_min, 0);
    check("arst_setting", setting, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // random mode/inc traffic with occasional asynchronous reset
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
      end else begin
        step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Sequencing controller for the digital-clock timekeeping chain.
- Generates the 1 Hz count enable from the system clock and drives six BCD digit counters (HH:MM:SS) with decade/mod-6/mod-24 carry sequencing.
- Runs a set-mode FSM so the user can adjust hours and minutes from two debounced button pulses.
- Sits between the button conditioning logic and the 7-segment display multiplexer.

Parameters:
- TICK_DIV, 100_000_000: system clocks per 1 Hz tick; minimum 2, must be even.
- START_HR, 0: hour loaded at reset, 0..23.
- START_MIN, 0: minute loaded at reset, 0..59.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-high: one clock, asynchronous active-high reset.
- mode_p  in  1  single-cycle pulse, advances set-mode FSM.
- inc_p  in  1  single-cycle pulse, increments the selected field in a set state.
- hr_t  out  4  hours tens, BCD 0..2.
- hr_o  out  4  hours ones, BCD 0..9.
- min_t  out  4  minutes tens, BCD 0..5.
- min_o  out  4  minutes ones, BCD 0..9.
- sec_t  out  4  seconds tens, BCD 0..5.
- sec_o  out  4  seconds ones, BCD 0..9.
- tick  out  1  one-cycle 1 Hz strobe, RUN state only.
- blank_hr  out  1  high in the blink-off half-period while in SET_HR.
- blank_min  out  1  high in the blink-off half-period while in SET_MIN.
- setting  out  1  high in SET_HR or SET_MIN.

Behaviour:
- Reset values:
  - Outputs: hours = START_HR, minutes = START_MIN, seconds = 00.
  - Internal: prescaler = 0, state = RUN.
  - Strobes and flags: tick = 0, blank_* = 0, setting = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps. It runs in all states.
  - tick is registered, high for exactly one cycle after the prescaler reads TICK_DIV-1, and only when state is RUN.
  - Blink phase = prescaler >= TICK_DIV/2.
- Count sequencing: all digits update on the cycle that tick is high.
  - sec_o 9 -> 0 carries to sec_t; sec_t:sec_o 59 -> 00 carries to min_o.
  - Minutes follow the same chain; 59 -> 00 carries to hours.
  - Hours: ones 9 -> 0 increments tens; 23 -> 00 wraps.
  - 23:59:59 -> 00:00:00 completes in a single cycle.
- FSM states are RUN, SET_HR and SET_MIN. Transitions happen on mode_p only:
  - RUN -> SET_HR: seconds are cleared to 00 on the same edge.
  - SET_HR -> SET_MIN.
  - SET_MIN -> RUN: prescaler is cleared to 0, so the first tick comes TICK_DIV cycles later.
- Adjust:
  - SET_HR: inc_p increments hours mod 24, with no effect on minutes.
  - SET_MIN: inc_p increments minutes mod 60, with no carry into hours.
  - RUN: inc_p is ignored.
- Simultaneous events:
  - mode_p and inc_p on the same cycle: mode_p wins and inc_p is dropped.
  - tick is suppressed in set states, so it never coincides with an adjust.
- Blanking: blank_hr = SET_HR AND blink phase; blank_min = SET_MIN AND blink phase. Both are combinational from registered state.
- Illegal digit values cannot be produced. An unused FSM encoding recovers to RUN on the next edge.
- Reset asserted mid-operation, including in a set state: all registers return to reset values immediately, with no clock required.

Decomposition:
- Shared package clock_ctrl_pkg holds:
  - the state enum (RUN, SET_HR, SET_MIN);
  - BCD digit limit constants (9, 5, 2, 3).
- One natural sub-module, bcd_digit: a 4-bit BCD digit register with parameter MAX.
  - Inputs: en, clr.
  - Output: carry, which equals en AND (value == MAX) and wraps the digit to 0.
  - Hours use two instances plus a top-level 23 -> 00 override.

Test Plan (all with TICK_DIV=4):
- Reset with START_HR=12, START_MIN=34 -> outputs 12:34:00, setting=0, first tick 4 cycles after reset release, seconds 00 -> 01.
- Preload 23:59:58 via set mode, return to RUN, apply 2 ticks -> 23:59:59 then 00:00:00 on the same cycle as the second tick.
- In RUN at 10:20:37, pulse mode_p -> state SET_HR, seconds 00, tick stays low for 20 cycles; 14 inc_p pulses -> hours 00 after wrapping through 23.
- In SET_MIN at 05:59, inc_p -> 05:00 with hours unchanged; mode_p -> RUN, tick exactly 4 cycles later.
- mode_p and inc_p in the same cycle while in SET_HR at 07 -> state SET_MIN, hours still 07.
- Assert rst asynchronously mid-cycle while in SET_MIN with blank_min=1 -> outputs return to START values and blank_min=0 before the next clk edge.
